router_vc_input_buffer: RTL

//  Parametrised router input port: NUM_VC virtual channels, each a DEPTH-entry FIFO of DATA_W-bit flits.

---
 rtl/router_vc_input_buffer.sv | 102 ++++++++++
 1 files changed

// File: rtl/router_vc_input_buffer.sv
// Router input port: NUM_VC virtual-channel FIFOs of DEPTH flits each, filled by a
// VC-tagged sender and drained one flit per cycle from the router-selected VC.
module router_vc_input_buffer #(
  parameter int DATA_W = 64,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4,
  parameter int VC_W   = $clog2(NUM_VC),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_send,
  input  logic [VC_W-1:0]         in_vc,
  input  logic [DATA_W-1:0]       in_data,
  output logic [NUM_VC-1:0]       in_ready,
  input  logic [VC_W-1:0]         out_vc_sel,
  input  logic                    out_blocked,
  output logic                    out_valid,
  output logic [VC_W-1:0]         out_vc,
  output logic [DATA_W-1:0]       out_data,
  output logic [NUM_VC*CNT_W-1:0] vc_count,
  output logic                    err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SLOTS = 1 << VC_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  count  [NUM_VC];

  // Padded to the full index range so out-of-range VC numbers read as
  // not-ready / empty and can never push or pop.
  logic [SLOTS-1:0]  slot_ready;
  logic [SLOTS-1:0]  slot_avail;
  logic [NUM_VC-1:0] push_hit;
  logic [NUM_VC-1:0] pop_hit;
  logic              push;
  logic              pop;

  always_comb begin
    in_ready   = '0;
    vc_count   = '0;
    slot_ready = '0;
    slot_avail = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      in_ready[v]                   = (count[v] != FULL);
      slot_ready[v]                 = (count[v] != FULL);
      slot_avail[v]                 = (count[v] != '0);
      vc_count[v*CNT_W +: CNT_W]    = count[v];
    end
  end

  assign push = in_send && slot_ready[in_vc];
  assign pop  = !out_blocked && slot_avail[out_vc_sel];

  always_comb begin
    push_hit = '0;
    pop_hit  = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      push_hit[v] = push && (in_vc == VC_W'(v));
      pop_hit[v]  = pop && (out_vc_sel == VC_W'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[in_vc][wr_ptr[in_vc]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        count[v]  <= '0;
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
      end
      out_valid    <= 1'b0;
      out_vc       <= '0;
      out_data     <= '0;
      err_overflow <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (push_hit[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (pop_hit[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        if (push_hit[v] && !pop_hit[v])      count[v] <= count[v] + CNT_W'(1);
        else if (!push_hit[v] && pop_hit[v]) count[v] <= count[v] - CNT_W'(1);
      end
      if (in_send && !push) err_overflow <= 1'b1;
      if (pop) begin
        out_valid <= 1'b1;
        out_vc    <= out_vc_sel;
        out_data  <= mem[out_vc_sel][rd_ptr[out_vc_sel]];
      end else begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end
    end
  end

endmodule
